// File: rtl/mux_nto1_seq.sv
// mux_nto1_seq: registered N:1 channel multiplexer with a valid/ready output
// stage. Channels are picked either by manual request (sel/in_valid) or by
// an automatic scan of channels 0..N-1 that is launched by a start pulse.
//
// Build option:
//   MUX_NTO1_RANGE_CHK_EN - when defined, a manual request with sel >= N is
//   consumed without producing a beat, and the sticky err flag is set.
//   When undefined, such a request produces a normal beat with zero data,
//   and err is tied low.
module mux_nto1_seq #(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  data_in,
  input  logic [SW-1:0]   sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            start,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    data_q, data_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            free;

`ifdef MUX_NTO1_RANGE_CHK_EN
  logic            err_q, err_d;
  logic            sel_hit;
`endif

  // Channel extraction; indices outside 0..N-1 read as zero.
  function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] bus,
                                             input logic [SW-1:0]  idx);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = bus[k*W +: W];
    end
    return r;
  endfunction

`ifdef MUX_NTO1_RANGE_CHK_EN
  function automatic logic chan_exists(input logic [SW-1:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == SW'(k)) r = 1'b1;
    end
    return r;
  endfunction
`endif

  // Next-state, output-stage load and handshake logic.
  always_comb begin
    free     = !valid_q || out_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ch_d     = ch_q;
    // An accepted beat empties the stage unless something reloads it below.
    valid_d  = valid_q && !out_ready;
    done_d   = 1'b0;
    in_ready = 1'b0;
`ifdef MUX_NTO1_RANGE_CHK_EN
    err_d    = err_q;
    sel_hit  = chan_exists(sel);
`endif

    case (state_q)
      S_IDLE: begin
        in_ready = free && !start;
        if (start) begin
          // Channel 0 is loaded on the start edge itself when the stage is
          // free, so the first scan beat appears one cycle after start.
          state_d = S_SCAN;
          cnt_d   = '0;
          if (free) begin
            data_d  = chan_data(data_in, '0);
            ch_d    = '0;
            valid_d = 1'b1;
            cnt_d   = SW'(1);
          end
        end else if (in_valid && in_ready) begin
`ifdef MUX_NTO1_RANGE_CHK_EN
          if (sel_hit) begin
            data_d  = chan_data(data_in, sel);
            ch_d    = sel;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
`else
          data_d  = chan_data(data_in, sel);
          ch_d    = sel;
          valid_d = 1'b1;
`endif
        end
      end

      S_SCAN: begin
        if (free) begin
          data_d  = chan_data(data_in, cnt_q);
          ch_d    = cnt_q;
          valid_d = 1'b1;
          if (cnt_q == LAST_CH) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + SW'(1);
          end
        end
      end

      S_DRAIN: begin
        // The only beat that can be held here is the last scan channel.
        if (valid_q && out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MUX_NTO1_RANGE_CHK_EN
  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Directed bench for mux_nto1_seq: manual requests (table driven) on an
// 8x4 instance and a 6x1 instance, plus scan, backpressure and reset
// sequences on the 8x4 instance.
module tb_mux_nto1_seq;

`ifdef MUX_NTO1_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // Instance A: N=8, W=4
  logic [31:0] a_data_in;
  logic [2:0]  a_sel;
  logic        a_in_valid, a_in_ready, a_start;
  logic [3:0]  a_out_data;
  logic [2:0]  a_out_ch;
  logic        a_out_valid, a_out_ready, a_busy, a_done, a_err;

  // Instance B: N=6, W=1 (non power of two, exercises out-of-range sel)
  logic [5:0]  b_data_in;
  logic [2:0]  b_sel;
  logic        b_in_valid, b_in_ready, b_start;
  logic        b_out_data;
  logic [2:0]  b_out_ch;
  logic        b_out_valid, b_out_ready, b_busy, b_done, b_err;

  int n_cmp = 0;
  int n_bad = 0;

  mux_nto1_seq #(.N(8), .W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .start(a_start),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .busy(a_busy), .done(a_done), .err(a_err)
  );

  mux_nto1_seq #(.N(6), .W(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .start(b_start),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit         dut_b;
    logic [2:0] sel;
    logic [3:0] exp_data;
    bit         exp_valid;
    bit         exp_err;
  } man_vec_t;

  man_vec_t vecs[17];

  initial begin
    int exp_k;
    int done_cnt;
    bit pat [4];

    // Manual table. A: data 32'h9E3C5A71 -> ch0..7 = 1,7,A,5,C,3,E,9.
    // B: data 6'b101010 -> ch0..5 = 0,1,0,1,0,1.
    vecs[0]  = '{1'b0, 3'd3, 4'h5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 4'h1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd7, 4'h9, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd5, 4'h3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 4'h7, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd6, 4'hE, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd2, 4'hA, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd4, 4'hC, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'd0, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 3'd1, 4'h1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 3'd2, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 3'd3, 4'h1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'd4, 4'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 3'd5, 4'h1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 3'd7, 4'h0, !CHK, CHK};
    vecs[15] = '{1'b1, 3'd2, 4'h0, 1'b1, CHK};
    vecs[16] = '{1'b1, 3'd5, 4'h1, 1'b1, CHK};

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_n = 1'b0;
    a_data_in = 32'h9E3C5A71; a_sel = '0; a_in_valid = 0; a_start = 0; a_out_ready = 1;
    b_data_in = 6'b101010;    b_sel = '0; b_in_valid = 0; b_start = 0; b_out_ready = 1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data, 0);
    chk("rst_a_ch",    a_out_ch, 0);
    chk("rst_a_busy",  a_busy, 0);
    chk("rst_a_done",  a_done, 0);
    chk("rst_a_err",   a_err, 0);
    chk("rst_b_err",   b_err, 0);
    chk("rst_a_inrdy", a_in_ready, 1);

    // Manual requests, back-to-back, one-cycle latency each
    for (int i = 0; i < 17; i++) begin
      a_in_valid = !vecs[i].dut_b;
      b_in_valid = vecs[i].dut_b;
      a_sel = vecs[i].sel;
      b_sel = vecs[i].sel;
      #1;
      if (vecs[i].dut_b) chk("man_b_inrdy", b_in_ready, 1);
      else               chk("man_a_inrdy", a_in_ready, 1);
      step();
      if (vecs[i].dut_b) begin
        chk("man_b_valid", b_out_valid, vecs[i].exp_valid);
        if (vecs[i].exp_valid) begin
          chk("man_b_data", {31'b0, b_out_data}, vecs[i].exp_data);
          chk("man_b_ch", b_out_ch, vecs[i].sel);
        end
        chk("man_b_err", b_err, vecs[i].exp_err);
      end else begin
        chk("man_a_valid", a_out_valid, vecs[i].exp_valid);
        chk("man_a_data", a_out_data, vecs[i].exp_data);
        chk("man_a_ch", a_out_ch, vecs[i].sel);
      end
    end
    a_in_valid = 0; b_in_valid = 0;
    step();
    chk("man_a_empty", a_out_valid, 0);
    chk("man_b_empty", b_out_valid, 0);

    // Scan with out_ready high; start collides with a manual request
    a_data_in = 32'h76543210;
    a_out_ready = 1;
    a_start = 1; a_in_valid = 1; a_sel = 3'd5;
    #1;
    chk("scan_start_inrdy", a_in_ready, 0);
    step();
    a_start = 0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_valid", a_out_valid, 1);
      chk("scan_ch", a_out_ch, k);
      chk("scan_data", a_out_data, k);
      chk("scan_busy", a_busy, 1);
      chk("scan_done", a_done, 0);
      if (k == 3) begin
        a_start = 1;
        #1;
        chk("scan_busy_inrdy", a_in_ready, 0);
      end
      if (k == 4) a_start = 0;
      if (k == 5) a_in_valid = 0;
      step();
    end
    chk("scan_done_pulse", a_done, 1);
    chk("scan_done_busy", a_busy, 0);
    chk("scan_done_valid", a_out_valid, 0);
    step();
    chk("scan_done_clr", a_done, 0);
    chk("scan_no_extra", a_out_valid, 0);

    // Scan under out_ready 1,0,0,1 with data_in disturbed during a stall
    exp_k = 0;
    done_cnt = 0;
    a_out_ready = 1;
    a_start = 1;
    step();
    a_start = 0;
    for (int i = 0; i < 100 && !(exp_k == 8 && done_cnt > 0); i++) begin
      a_out_ready = pat[i % 4];
      if (a_out_valid) begin
        chk("bp_ch", a_out_ch, exp_k);
        chk("bp_data", a_out_data, exp_k[3:0]);
        if (a_out_ready) exp_k++;
      end
      if (a_done) done_cnt++;
      chk("bp_done_busy_excl", a_done & a_busy, 0);
      if (i % 4 == 1) a_data_in = ~32'h76543210;
      if (i % 4 == 2) a_data_in = 32'h76543210;
      step();
    end
    a_out_ready = 1;
    a_data_in = 32'h76543210;
    chk("bp_beats", exp_k, 8);
    chk("bp_done_count", done_cnt, 1);
    step();
    chk("bp_idle_valid", a_out_valid, 0);
    chk("bp_idle_busy", a_busy, 0);

    // Reset mid-scan after beat 3
    a_start = 1;
    step();
    a_start = 0;
    step(); step(); step();
    chk("rs_beat3", a_out_ch, 3);
    rst_n = 0;
    #1;
    chk("rs_async_valid", a_out_valid, 0);
    chk("rs_async_data", a_out_data, 0);
    chk("rs_async_ch", a_out_ch, 0);
    chk("rs_async_busy", a_busy, 0);
    chk("rs_async_done", a_done, 0);
    chk("rs_async_berr", b_err, 0);
    step(); step();
    rst_n = 1;
    step();
    chk("rs_post_done", a_done, 0);
    chk("rs_post_busy", a_busy, 0);
    chk("rs_post_valid", a_out_valid, 0);
    a_start = 1;
    step();
    a_start = 0;
    chk("rs_fresh_ch", a_out_ch, 0);
    chk("rs_fresh_data", a_out_data, 0);
    chk("rs_fresh_valid", a_out_valid, 1);
    chk("rs_fresh_busy", a_busy, 1);
    for (int k = 0; k < 8; k++) step();
    chk("rs_fresh_done", a_done, 1);
    chk("rs_fresh_idle", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
